// File: rtl/pent1m_ports.sv
// Z80 I/O-write decoder and memory-configuration register file for the ATM pagers.
// Latches 7FFD / EFF7 / xx77, strobes the xxF7 pager ports and tracks the DOS flag.
module pent1m_ports (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [3:0]  dos_turn_on,
  input  logic [3:0]  dos_turn_off,
  output logic [5:0]  pent1m_page,
  output logic        pent1m_ROM,
  output logic        pent1m_scr,
  output logic        pent1m_ram0_0,
  output logic        pent1m_1m_on,
  output logic        pager_off,
  output logic        atm_xxF7_wr,
  output logic        dos
);

  logic       r_iowr;
  logic [5:0] r_page;
  logic       r_rom;
  logic       r_scr;
  logic       r_ram0_0;
  logic       r_eff7_b2;
  logic       r_lock;
  logic       r_pager_off;
  logic       r_dos;

  logic       w_iowr;
  logic       w_port_stb;
  logic       w_wr_7ffd;
  logic       w_wr_eff7;
  logic       w_wr_xx77;
  logic       w_1m_on;
  logic [1:0] w_sel;
  logic       w_unused;

  assign w_iowr     = ~iorq_n & ~wr_n & m1_n;
  // Rising edge of the write request as seen at zpos: one strobe per I/O cycle.
  assign w_port_stb = zpos & w_iowr & ~r_iowr;

  assign w_wr_7ffd  = w_port_stb & ~za[15] & (za[7:0] == 8'hFD);
  assign w_wr_eff7  = w_port_stb & (za[15:12] == 4'hE) & (za[7:0] == 8'hF7);
  assign w_wr_xx77  = w_port_stb & (za[7:0] == 8'h77) & r_dos;
  assign w_1m_on    = ~r_eff7_b2;
  assign w_sel      = za[15:14];

  // Combinational so the pagers latch on the very edge that za/zd are still valid.
  assign atm_xxF7_wr = w_port_stb & (za[7:0] == 8'hF7) & (za[13:12] == 2'b11) & r_dos;

  // zneg and the middle address byte take no part in these decodes.
  assign w_unused = ^{zneg, za[11:8]};

  // NOTE: all state here is sequential and uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours (lock, 1m_on, dos).
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_iowr <= 1'b0;
    end else if (zpos) begin
      r_iowr <= w_iowr;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_page      <= '0;
      r_rom       <= 1'b0;
      r_scr       <= 1'b0;
      r_ram0_0    <= 1'b0;
      r_eff7_b2   <= 1'b0;
      r_lock      <= 1'b0;
      r_pager_off <= 1'b0;
    end else begin
      if (w_wr_eff7) begin
        r_eff7_b2 <= zd[2];
        r_ram0_0  <= zd[3];
        r_lock    <= 1'b0;
      end
      // In 128K mode a locked 7FFD ignores writes until EFF7 is written again.
      if (w_wr_7ffd && !(r_lock && !w_1m_on)) begin
        r_page[2:0] <= zd[2:0];
        r_scr       <= zd[3];
        r_rom       <= zd[4];
        if (w_1m_on) begin
          r_page[5]   <= zd[5];
          r_page[4:3] <= zd[7:6];
        end else begin
          r_page[5:3] <= 3'b000;
          r_lock      <= zd[5];
        end
      end
      if (w_wr_xx77) begin
        r_pager_off <= ~zd[1];
      end
    end
  end

  // Only the pager owning the window of the current address may flip DOS; on beats off.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_dos <= 1'b0;
    end else if (dos_turn_on[w_sel]) begin
      r_dos <= 1'b1;
    end else if (dos_turn_off[w_sel]) begin
      r_dos <= 1'b0;
    end
  end

  assign pent1m_page   = r_page;
  assign pent1m_ROM    = r_rom;
  assign pent1m_scr    = r_scr;
  assign pent1m_ram0_0 = r_ram0_0;
  assign pent1m_1m_on  = w_1m_on;
  assign pager_off     = r_pager_off;
  assign dos           = r_dos;

endmodule
